lockstep_mode_ctrl: RTL and testbench

- Sequences safe entry into and exit from lockstep mode for the 8-port lockstep memory-alignment unit.
- On a mode-change request it halts core request issue, drains all outstanding memory transactions, flips the mode, and lets the alignment FSMs settle before releasing the cores.
- Sits between the cluster config register (requested mode) and the lockstep unit's lockstep_mode input.
- Snoops the memory-side req/gnt/rvalid of every port.

---
 rtl/lockstep_pkg.sv | 14 +
 rtl/lockstep_mode_ctrl_outst_counter.sv | 37 +++
 rtl/lockstep_mode_ctrl.sv | 172 +++++++++++++++++
 tb/tb_lockstep_mode_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lockstep_pkg.sv
package lockstep_pkg;

  localparam int unsigned NUM_PORTS_DEFAULT = 8;
  localparam int unsigned OUTST_W_DEFAULT   = 3;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_HALT   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SWITCH = 3'd3,
    ST_SETTLE = 3'd4
  } lockstep_ctrl_state_e;

endpackage

// File: rtl/lockstep_mode_ctrl_outst_counter.sv
module outst_counter
  import lockstep_pkg::*;
#(
  parameter int unsigned OUTST_W = OUTST_W_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [OUTST_W-1:0] cnt_o,
  output logic               underflow_o,
  output logic               overflow_o
);

  logic [OUTST_W-1:0] r_cnt;
  logic               w_up;
  logic               w_dn;

  always_comb begin
    w_up        = inc_i & ~dec_i;
    w_dn        = dec_i & ~inc_i;
    overflow_o  = w_up && (r_cnt == '1);
    underflow_o = w_dn && (r_cnt == '0);
    cnt_o       = r_cnt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_up && !overflow_o) begin
      r_cnt <= r_cnt + OUTST_W'(1);
    end else if (w_dn && !underflow_o) begin
      r_cnt <= r_cnt - OUTST_W'(1);
    end
  end

endmodule

// File: rtl/lockstep_mode_ctrl.sv
module lockstep_mode_ctrl
  import lockstep_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = NUM_PORTS_DEFAULT,
  parameter int unsigned OUTST_W     = OUTST_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned SETTLE_CYC  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_lockstep_en_i,
  input  logic                 clear_i,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] gnt_i,
  input  logic [NUM_PORTS-1:0] rvalid_i,
  output logic [NUM_PORTS-1:0] core_halt_o,
  output logic                 lockstep_mode_o,
  output logic                 busy_o,
  output logic                 switch_done_o,
  output logic                 timeout_o,
  output logic                 proto_err_o,
  output logic [2:0]           state_o
);

  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned STL_W = $clog2(SETTLE_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [STL_W-1:0] STL_LOAD = STL_W'(SETTLE_CYC - 1);

  lockstep_ctrl_state_e r_state;
  lockstep_ctrl_state_e w_state_nxt;

  logic                 r_mode;
  logic                 r_target;
  logic                 r_done;
  logic                 r_tmo;
  logic                 r_perr;
  logic [TMO_W-1:0]     r_tmo_cnt;
  logic [STL_W-1:0]     r_stl_cnt;

  logic [NUM_PORTS-1:0] w_uf;
  logic [NUM_PORTS-1:0] w_of;
  logic [NUM_PORTS-1:0] w_cnt_nz;
  logic                 w_idle_all;
  logic                 w_start;
  logic                 w_flip;
  logic                 w_tmo_set;
  logic                 w_stl_load;
  logic                 w_done;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic [OUTST_W-1:0] w_cnt;

    outst_counter #(
      .OUTST_W (OUTST_W)
    ) u_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .inc_i       (req_i[g] & gnt_i[g]),
      .dec_i       (rvalid_i[g]),
      .cnt_o       (w_cnt),
      .underflow_o (w_uf[g]),
      .overflow_o  (w_of[g])
    );

    assign w_cnt_nz[g] = |w_cnt;
  end

  always_comb begin
    w_idle_all  = ~|req_i && ~|w_cnt_nz;
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_flip      = 1'b0;
    w_tmo_set   = 1'b0;
    w_stl_load  = 1'b0;
    w_done      = 1'b0;

    unique case (r_state)
      ST_RUN: begin
        if ((cfg_lockstep_en_i != r_mode) && !r_tmo) begin
          w_start     = 1'b1;
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Mode register loads on the DRAIN->SWITCH edge, so the new mode is
        // already visible while in SWITCH.
        if (w_idle_all) begin
          w_flip      = 1'b1;
          w_state_nxt = ST_SWITCH;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_tmo_set   = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_SWITCH: begin
        w_stl_load  = 1'b1;
        w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_stl_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_RUN;
      r_mode    <= 1'b0;
      r_target  <= 1'b0;
      r_done    <= 1'b0;
      r_tmo     <= 1'b0;
      r_perr    <= 1'b0;
      r_tmo_cnt <= '0;
      r_stl_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done;

      if (w_start) begin
        r_target <= cfg_lockstep_en_i;
      end
      if (w_flip) begin
        r_mode <= r_target;
      end

      if (r_state == ST_HALT) begin
        r_tmo_cnt <= '0;
      end else if (r_state == ST_DRAIN) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end

      if (w_stl_load) begin
        r_stl_cnt <= STL_LOAD;
      end else if ((r_state == ST_SETTLE) && (r_stl_cnt != '0)) begin
        r_stl_cnt <= r_stl_cnt - STL_W'(1);
      end

      if (clear_i) begin
        r_tmo <= 1'b0;
      end else if (w_tmo_set) begin
        r_tmo <= 1'b1;
      end

      if (clear_i) begin
        r_perr <= 1'b0;
      end else if (|w_uf || |w_of) begin
        r_perr <= 1'b1;
      end
    end
  end

  always_comb begin
    core_halt_o     = {NUM_PORTS{r_state != ST_RUN}};
    busy_o          = (r_state != ST_RUN);
    lockstep_mode_o = r_mode;
    switch_done_o   = r_done;
    timeout_o       = r_tmo;
    proto_err_o     = r_perr;
    state_o         = r_state;
  end

endmodule

// File: tb/tb_lockstep_mode_ctrl.sv
module tb_lockstep_mode_ctrl;

  localparam int unsigned NP   = 8;
  localparam int unsigned OW   = 3;
  localparam int unsigned TMO  = 16;
  localparam int unsigned STL  = 2;
  localparam int unsigned VW   = NP + 8;
  localparam int          MAXC = (1 << OW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg;
  logic          clr;
  logic [NP-1:0] req;
  logic [NP-1:0] gnt;
  logic [NP-1:0] rvalid;
  logic [NP-1:0] core_halt;
  logic          lmode;
  logic          busy;
  logic          sdone;
  logic          tmo;
  logic          perr;
  logic [2:0]    state;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0..4 = RUN, HALT, DRAIN, SWITCH, SETTLE
  int m_cnt[NP];
  int m_phase;
  int m_drain_n;
  int m_settle_n;
  bit m_mode;
  bit m_target;
  bit m_done;
  bit m_tmo;
  bit m_perr;

  lockstep_mode_ctrl #(
    .NUM_PORTS   (NP),
    .OUTST_W     (OW),
    .TIMEOUT_CYC (TMO),
    .SETTLE_CYC  (STL)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .cfg_lockstep_en_i (cfg),
    .clear_i           (clr),
    .req_i             (req),
    .gnt_i             (gnt),
    .rvalid_i          (rvalid),
    .core_halt_o       (core_halt),
    .lockstep_mode_o   (lmode),
    .busy_o            (busy),
    .switch_done_o     (sdone),
    .timeout_o         (tmo),
    .proto_err_o       (perr),
    .state_o           (state)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] obs_vec();
    return {core_halt, lmode, busy, sdone, tmo, perr, state};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic h;
    h = (m_phase != 0);
    return {{NP{h}}, m_mode, h, m_done, m_tmo, m_perr, 3'(m_phase)};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) m_cnt[p] = 0;
    m_phase = 0; m_drain_n = 0; m_settle_n = 0;
    m_mode = 0; m_target = 0; m_done = 0; m_tmo = 0; m_perr = 0;
  endtask

  task automatic model_step();
    bit idle, err, tset, dn;
    if (rst) begin
      model_reset();
      return;
    end
    idle = (req == '0);
    for (int p = 0; p < NP; p++) if (m_cnt[p] != 0) idle = 0;
    err = 0; tset = 0; dn = 0;
    for (int p = 0; p < NP; p++) begin
      if ((req[p] && gnt[p]) && !rvalid[p]) begin
        if (m_cnt[p] == MAXC) err = 1; else m_cnt[p]++;
      end else if (rvalid[p] && !(req[p] && gnt[p])) begin
        if (m_cnt[p] == 0) err = 1; else m_cnt[p]--;
      end
    end
    case (m_phase)
      0: if (cfg != m_mode && !m_tmo) begin m_target = cfg; m_phase = 1; end
      1: begin m_phase = 2; m_drain_n = 0; end
      2: begin
        if (idle) begin m_phase = 3; m_mode = m_target; end
        else if (m_drain_n + 1 == TMO) begin tset = 1; m_phase = 0; end
        else m_drain_n++;
      end
      3: begin m_phase = 4; m_settle_n = 0; end
      default: begin
        if (m_settle_n + 1 == STL) begin m_phase = 0; dn = 1; end
        else m_settle_n++;
      end
    endcase
    m_done = dn;
    m_tmo  = clr ? 1'b0 : (tset ? 1'b1 : m_tmo);
    m_perr = clr ? 1'b0 : (err ? 1'b1 : m_perr);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    req = '0; gnt = '0; rvalid = '0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg = 1'b0; drive_idle(); model_reset();
    cyc(); cyc();
    total++;
    if (obs_vec() !== {VW{1'b0}}) begin
      bad++; $display("FAIL reset_vals: got %h want %h", obs_vec(), {VW{1'b0}});
    end
    rst = 1'b0;
    cyc();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_clean_entry();
    drive_idle(); cfg = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL clean_entry c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 1) begin
        total++;
        if (core_halt !== 8'hFF) begin bad++; $display("FAIL clean_halt: got %h want ff", core_halt); end
      end
      if (c == 2 || c == 3) begin
        total++;
        if (lmode !== (c == 3)) begin bad++; $display("FAIL clean_mode c%0d: got %b want %b", c, lmode, c == 3); end
      end
      if (c == 5 || c == 6 || c == 7) begin
        total++;
        if (sdone !== (c == 6)) begin bad++; $display("FAIL clean_done c%0d: got %b want %b", c, sdone, c == 6); end
      end
      if (c == 6) begin
        total++;
        if (core_halt !== 8'h00) begin bad++; $display("FAIL clean_release: got %h want 00", core_halt); end
      end
    end
  endtask

  task automatic test_drain_wait();
    drive_idle();
    req[2] = 1'b1; gnt[2] = 1'b1;
    cyc(); cyc();
    drive_idle(); cfg = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      cyc();
      rvalid = (c == 5 || c == 9) ? 8'h04 : 8'h00;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL drain_wait c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 10) begin
        total++;
        if (lmode !== 1'b1 || state !== 3'd2) begin
          bad++; $display("FAIL drain_hold: got mode=%b st=%0d want mode=1 st=2", lmode, state);
        end
      end
      if (c == 11) begin
        total++;
        if (lmode !== 1'b0 || state !== 3'd3) begin
          bad++; $display("FAIL drain_flip: got mode=%b st=%0d want mode=0 st=3", lmode, state);
        end
      end
    end
  endtask

  task automatic test_pending_req();
    drive_idle(); cfg = 1'b1; req[5] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      req[5]    = (c <= 4);
      gnt[5]    = (c == 4);
      rvalid[5] = (c == 6);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL pending_req c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c <= 7) begin
        total++;
        if (state === 3'd3) begin bad++; $display("FAIL pending_early c%0d: got st=3 want st!=3", c); end
      end
      if (c == 8) begin
        total++;
        if (state !== 3'd3 || lmode !== 1'b1) begin
          bad++; $display("FAIL pending_switch: got st=%0d mode=%b want st=3 mode=1", state, lmode);
        end
      end
    end
  endtask

  task automatic test_timeout();
    drive_idle(); req[0] = 1'b1; gnt[0] = 1'b1;
    cyc();
    drive_idle(); cfg = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      cyc();
      clr       = (c == 22);
      rvalid[0] = (c == 22);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL timeout c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 17) begin
        total++;
        if (state !== 3'd2 || tmo !== 1'b0) begin
          bad++; $display("FAIL tmo_last_drain: got st=%0d tmo=%b want st=2 tmo=0", state, tmo);
        end
      end
      if (c == 18) begin
        total++;
        if (tmo !== 1'b1 || state !== 3'd0 || lmode !== 1'b1 || core_halt !== 8'h00) begin
          bad++; $display("FAIL tmo_abort: got tmo=%b st=%0d mode=%b halt=%h want 1 0 1 00", tmo, state, lmode, core_halt);
        end
      end
      if (c == 22 || c == 23) begin
        total++;
        if (state !== 3'd0) begin bad++; $display("FAIL tmo_no_retry c%0d: got st=%0d want 0", c, state); end
      end
      if (c == 24) begin
        total++;
        if (state !== 3'd1 || tmo !== 1'b0) begin
          bad++; $display("FAIL tmo_retry: got st=%0d tmo=%b want st=1 tmo=0", state, tmo);
        end
      end
      if (c == 26) begin
        total++;
        if (lmode !== 1'b0) begin bad++; $display("FAIL tmo_retry_flip: got %b want 0", lmode); end
      end
    end
  endtask

  task automatic test_proto_err();
    drive_idle(); rvalid[7] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      req[3]    = (c >= 3 && c <= 10);
      gnt[3]    = (c >= 3 && c <= 10);
      rvalid    = (c >= 11 && c <= 17) ? 8'h08 : 8'h00;
      clr       = (c == 2 || c == 18);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL proto_err c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 1 || c == 3 || c == 10 || c == 11 || c == 19) begin
        total++;
        if (perr !== (c == 1 || c == 11)) begin
          bad++; $display("FAIL proto_flag c%0d: got %b want %b", c, perr, (c == 1 || c == 11));
        end
      end
      if (c == 20) begin
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL proto_busy: got %b want 0", busy); end
      end
    end
  endtask

  task automatic test_async_reset();
    drive_idle(); cfg = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL areset_seq c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    total++;
    if (state !== 3'd4 || lmode !== 1'b1) begin
      bad++; $display("FAIL areset_pre: got st=%0d mode=%b want st=4 mode=1", state, lmode);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs_vec() !== {VW{1'b0}}) begin
      bad++; $display("FAIL areset_async: got %h want %h", obs_vec(), {VW{1'b0}});
    end
    model_reset(); cfg = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL areset_after: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    bit burst;
    burst = 1'b0;
    drive_idle();
    for (int i = 0; i < 600; i++) begin
      if ($urandom % 25 == 0) cfg = ~cfg;
      if ($urandom % 12 == 0) burst = ~burst;
      clr = ($urandom % 40 == 0);
      for (int p = 0; p < NP; p++) begin
        req[p]    = burst && ($urandom % 4 == 0);
        gnt[p]    = req[p] && ($urandom % 2 == 0);
        rvalid[p] = (m_cnt[p] > 0 && $urandom % 3 == 0) || ($urandom % 200 == 0);
      end
      cyc();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random i%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_entry();
    test_drain_wait();
    test_pending_req();
    test_timeout();
    test_proto_err();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
